// File: rtl/sub32_pkg.sv
// Shared definitions for the sequential subtractor.
//   - state_e : controller states (IDLE, CALC, DONE)
//   - WIDTH_DEF / SLICE_DEF : default operand width and per-cycle slice width
//   - NSLICE : number of slices per operand at the default sizes
//   - IDX_W  : slice index width, never narrower than one bit
package sub32_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SLICE_DEF = 16;
    localparam int NSLICE    = WIDTH_DEF / SLICE_DEF;
    localparam int IDX_W     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sub16_slice.sv
// Combinational slice subtractor: {cout, s} = x + ~y + cin.
// A full subtraction is chained slice by slice with cin=1 on the lowest slice.
//   x    : minuend slice
//   y    : subtrahend slice
//   cin  : incoming carry (1 = no borrow)
//   s    : difference slice
//   cout : outgoing carry (0 = borrow out)
module sub16_slice #(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    // Widen by one bit so the top bit of the sum is the carry out.
    assign {cout, s} = {1'b0, x} + {1'b0, ~y} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/sub32_seq.sv
// Multi-cycle two's-complement subtractor, diff = a - b, one SLICE-bit slice
// per clock through a single shared slice subtractor, LSB slice first.
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (accepted only in IDLE)
//   a, b                : minuend, subtrahend
//   out_valid/out_ready : result handshake (result held in DONE)
//   diff                : a - b modulo 2^WIDTH
//   borrow              : unsigned a < b
//   overflow            : signed overflow of the subtraction
//   zero                : diff == 0
module sub32_seq
    import sub32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int N_SL   = WIDTH / SLICE;
    localparam int SIDX_W = (N_SL > 1) ? $clog2(N_SL) : 1;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [WIDTH-1:0]    diff_q, diff_d;
    logic [SIDX_W-1:0]   idx_q, idx_d;
    logic                carry_q, carry_d;
    logic                borrow_q, borrow_d;
    logic                overflow_q, overflow_d;
    logic                zero_q, zero_d;

    logic [SLICE-1:0]    slice_x;
    logic [SLICE-1:0]    slice_y;
    logic [SLICE-1:0]    slice_s;
    logic                slice_cout;

    // Operand slices selected by the current slice index.
    assign slice_x = a_q[int'(idx_q)*SLICE +: SLICE];
    assign slice_y = b_q[int'(idx_q)*SLICE +: SLICE];

    sub16_slice #(.SLICE(SLICE)) u_slice (
        .x    (slice_x),
        .y    (slice_y),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // in_ready is masked by rst so it reads 0 in the reset cycle and 1
    // immediately after release, without waiting an extra edge.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

    // Next-state and datapath update for the IDLE/CALC/DONE controller.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        diff_d     = diff_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = {SIDX_W{1'b0}};
                    carry_d = 1'b1;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                diff_d[int'(idx_q)*SLICE +: SLICE] = slice_s;
                carry_d = slice_cout;
                idx_d   = idx_q + SIDX_W'(1);
                if (idx_q == SIDX_W'(N_SL - 1)) begin
                    // Flags are resolved on the last slice so they are
                    // registered and stable for the whole DONE state.
                    state_d    = DONE;
                    borrow_d   = ~slice_cout;
                    overflow_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                 (diff_d[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d     = (diff_d == {WIDTH{1'b0}});
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= {WIDTH{1'b0}};
            b_q        <= {WIDTH{1'b0}};
            diff_q     <= {WIDTH{1'b0}};
            idx_q      <= {SIDX_W{1'b0}};
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            diff_q     <= diff_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

endmodule

// File: tb/tb_sub32_seq.sv
module tb_sub32_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow;
    logic        overflow;
    logic        zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] diff;
        logic        borrow;
        logic        overflow;
        logic        zero;
    } vec_t;

    vec_t vecs[8];

    sub32_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    function automatic vec_t model(input logic [31:0] x, input logic [31:0] y);
        vec_t r;
        longint sx, sy, sd;
        r.a = x;
        r.b = y;
        r.diff = x - y;
        r.borrow = (x < y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sd = sx - sy;
        r.overflow = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        r.zero = (x == y);
        return r;
    endfunction

    // Issue one operation, check latency and the result, then consume it.
    task automatic run_op(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a = v.a;
        b = v.b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 0;
        while (lat < 8) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        check({tag, ".latency"}, 64'(lat), 64'd2);
        @(negedge clk);
        check({tag, ".diff"}, 64'(diff), 64'(v.diff));
        check({tag, ".borrow"}, 64'(borrow), 64'(v.borrow));
        check({tag, ".overflow"}, 64'(overflow), 64'(v.overflow));
        check({tag, ".zero"}, 64'(zero), 64'(v.zero));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".out_valid_drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        vec_t v;
        logic [31:0] held;
        logic        seen;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 32'd0;
        b = 32'd0;

        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{32'h1234_5678, 32'h0000_5679, 32'h1233_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFE_0001, 1'b0, 1'b0, 1'b0};

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.diff", 64'(diff), 64'd0);
        check("rst.borrow", 64'(borrow), 64'd0);
        check("rst.overflow", 64'(overflow), 64'd0);
        check("rst.zero", 64'(zero), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.in_ready_after", 64'(in_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            v = model($urandom, (i % 5 == 0) ? 32'($urandom_range(0, 3)) : $urandom);
            if (i % 7 == 0) v = model(v.a, v.a);
            run_op(v, $sformatf("rnd%0d", i));
        end

        // Backpressure: result held for 5 cycles, in_valid pulses ignored.
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'h0000_0005;
        b = 32'h0000_0003;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("bp.out_valid_rise", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = i[0];
            a = 32'hDEAD_BEEF;
            b = 32'h0000_0001;
            check("bp.out_valid", 64'(out_valid), 64'd1);
            check("bp.in_ready", 64'(in_ready), 64'd0);
            check("bp.diff", 64'(diff), 64'd2);
            check("bp.borrow", 64'(borrow), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp.release", 64'(out_valid), 64'd0);
        check("bp.idle_ready", 64'(in_ready), 64'd1);

        // Reset during CALC: operation aborted, no result ever appears.
        @(negedge clk);
        in_valid = 1'b1;
        a = 32'h0000_0009;
        b = 32'h0000_0004;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort.out_valid", 64'(out_valid), 64'd0);
        check("abort.diff", 64'(diff), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort.in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort.no_result", 64'(seen), 64'd0);

        v = '{32'h0000_FFFF, 32'h0000_0001, 32'h0000_FFFE, 1'b0, 1'b0, 1'b0};
        run_op(v, "post_abort");
        held = diff;
        check("hold_after_done", 64'(held), 64'h0000_FFFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
